// File: rtl/cut_io_pkg.sv
// Shared definitions for the CUT I/O interface: handshake FSM states and the
// default block geometry that both the input deserializer and output serializer use.
package cut_io_pkg;

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  localparam int CUT_DATA_WIDTH = 32;
  localparam int CUT_DEPTH      = 16;

endpackage

// File: rtl/input_deserializer.sv
// Assembles DEPTH serial words into one parallel block and holds the block
// until the consumer acknowledges it; a flush closes a partial block zero-padded.
module input_deserializer
  import cut_io_pkg::*;
#(
  parameter int  DATA_WIDTH = CUT_DATA_WIDTH,
  parameter int  DEPTH      = CUT_DEPTH,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [DATA_WIDTH-1:0]       in_data,
  output logic                        in_ready,
  input  logic                        flush,
  output logic                        out_valid,
  output logic [DEPTH*DATA_WIDTH-1:0] out_data,
  input  logic                        out_ack,
  output logic [CNT_W-1:0]            word_count
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

  state_t                  state_r;
  logic [CNT_W-1:0]        count_r;
  logic                    out_valid_r;
  logic [DATA_WIDTH-1:0]   slot_r [DEPTH];

  logic                    fill_s;
  logic                    accept_s;
  logic                    close_s;
  logic                    clear_s;
  logic [DEPTH-1:0]        wr_en_s;
  logic [DEPTH-1:0]        pad_s;

  assign fill_s     = (state_r == ST_FILL);
  assign in_ready   = rst & fill_s;
  assign accept_s   = in_valid & in_ready;
  // A flush only closes the block if it would carry at least one real word.
  assign close_s    = rst & fill_s & flush & ((count_r != {CNT_W{1'b0}}) | accept_s);
  assign clear_s    = (state_r == ST_FULL) & out_ack;
  assign out_valid  = out_valid_r;
  assign word_count = count_r;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
      localparam logic [CNT_W-1:0] IDX = CNT_W'(i);

      // Slots above the last real word are zeroed when a flush closes the block.
      assign wr_en_s[i] = accept_s & (count_r == IDX);
      assign pad_s[i]   = close_s & ((count_r < IDX) | ((count_r == IDX) & ~accept_s));

      // Per-slot storage: cleared on reset/ack, loaded on its index, padded on flush.
      always_ff @(posedge clk) begin
        if (!rst) begin
          slot_r[i] <= {DATA_WIDTH{1'b0}};
        end else if (clear_s) begin
          slot_r[i] <= {DATA_WIDTH{1'b0}};
        end else if (wr_en_s[i]) begin
          slot_r[i] <= in_data;
        end else if (pad_s[i]) begin
          slot_r[i] <= {DATA_WIDTH{1'b0}};
        end else begin
          slot_r[i] <= slot_r[i];
        end
      end

      assign out_data[i*DATA_WIDTH +: DATA_WIDTH] = slot_r[i];
    end
  endgenerate

  // Block FSM: word counting in FILL, hold-until-ack in FULL.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= ST_FILL;
      count_r     <= {CNT_W{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_FILL: begin
          if (accept_s) begin
            count_r <= count_r + CNT_W'(1);
          end
          if (close_s || (accept_s && (count_r == LAST_IDX))) begin
            state_r     <= ST_FULL;
            out_valid_r <= 1'b1;
          end
        end
        ST_FULL: begin
          if (out_ack) begin
            state_r     <= ST_FILL;
            count_r     <= {CNT_W{1'b0}};
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_FILL;
          count_r     <= {CNT_W{1'b0}};
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/input_deserializer.md
Name: input_deserializer

Overview:
- Upstream counterpart of the CUT output serializer in the CUT I/O interface.
- Accepts DATA_WIDTH-bit words one per cycle over a valid/ready handshake and assembles DEPTH words into one parallel DEPTH*DATA_WIDTH vector for the tensor-core CUT.
- Holds the assembled vector stable until the consumer acknowledges it.
- Supports flushing a partial block with zero padding.

Parameters:
- DATA_WIDTH, 32, width of one serial word.
- DEPTH, 16, number of words per parallel block (>=2).
- CNT_W, $clog2(DEPTH+1), width of word_count; derived, not overridden.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous reset, active-low.
- in_valid  input  1  upstream presents in_data.
- in_data  input  DATA_WIDTH  serial word.
- in_ready  output  1  block can accept a word this cycle.
- flush  input  1  close the current partial block, padding the rest with zeros.
- out_valid  output  1  out_data holds a complete block.
- out_data  output  DEPTH*DATA_WIDTH  assembled block; word i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_ack  input  1  consumer has taken out_data.
- word_count  output  CNT_W  words accepted into the current block (0..DEPTH).

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-low.
- Reset (rst low at a posedge):
  - state=FILL, word_count=0, out_valid=0.
  - All DEPTH word slots cleared to 0.
  - in_ready is 0 while rst is low (gated combinationally).
  - Reset mid-fill or mid-hold discards everything.
- FSM states: FILL and FULL.
- FILL:
  - in_ready=1 (when rst high), out_valid=0.
  - Accept happens when in_valid & in_ready: write in_data to slot word_count, word_count+1.
  - Word 0 is the first word accepted, so ordering matches the downstream serializer (slot 0 emitted first).
  - On accept with word_count==DEPTH-1: go to FULL; word_count becomes DEPTH.
- flush in FILL:
  - If word_count>0, or an accept happens the same cycle: the accepted word (if any) is written first, slots above it are written 0, and the state goes to FULL.
  - word_count reflects real words written.
  - flush with word_count==0 and no accept: ignored.
- FULL:
  - in_ready=0, out_valid=1, out_data stable.
  - in_valid and flush are ignored.
  - On out_ack: clear all slots to 0, word_count=0, go to FILL.
- out_ack while in FILL: ignored.
- Latency:
  - Last word accepted at posedge N gives out_valid=1 after posedge N.
  - out_ack sampled at posedge M gives in_ready=1 and out_valid=0 after posedge M.
  - Minimum gap between blocks is one cycle of in_ready=1 following the ack.
- Outputs are registered except in_ready (state decode gated by rst). out_valid = (state==FULL).
- Write index never wraps: FULL blocks writes, so slot DEPTH is never addressed.

Decomposition:
- Shared package cut_io_pkg:
  - state enum {ST_FILL, ST_FULL} with 1-bit encoding.
  - Default DATA_WIDTH/DEPTH constants, shared with the output serializer so both ends agree on block geometry.
- Single module, no sub-module. The slot write-enable decode (index compare plus flush padding) is a generate loop over DEPTH.

Test Plan (DATA_WIDTH=8, DEPTH=4):
- Full block: after reset send 0x11,0x22,0x33,0x44 back-to-back -> out_valid=1 the cycle after 0x44, out_data=0x44332211, word_count=4, in_ready=0.
- Hold/backpressure: in FULL, drive in_valid with 0x55 for 5 cycles, no ack -> out_data stays 0x44332211; then out_ack -> next cycle out_valid=0, in_ready=1, word_count=0, out_data=0; next word 0x66 lands in slot 0.
- Flush partial: send 0xA1,0xB2, then flush alone -> out_valid=1, out_data=0x0000B2A1, word_count=2; flush at word_count=0 -> no change.
- Flush with accept: send 0x01, then in_valid=1 with 0x02 plus flush in the same cycle -> out_data=0x00000201, word_count=2.
- Gapped input: send 0x10,0x20,0x30,0x40 with in_valid low 1-3 cycles between them -> same result as back-to-back, 0x40302010.
- Reset mid-operation: accept 3 words, assert rst for one cycle -> word_count=0, out_data=0, out_valid=0, in_ready=0 during reset and 1 after; a following 4-word block assembles correctly.
